clk_lock_seq: RTL and testbench
===============================

// Module: clk_lock_seq
// PURPOSE
//   Sequences the clock wizard: drives its reset, waits for lock, and qualifies lock stability.
//   Releases a clean synchronous active-low reset (sys_rst_n) to the counter/LED datapath.
//   Retries the PLL on lock timeout and re-sequences when lock is lost.
//   Runs on the board input clock, upstream of every clk_wiz-derived domain.
// PARAMETERS
//   RST_CYC      16         cycles pll_reset is held high per attempt (>=1)
//   LOCK_TIMEOUT 1_000_000  max cycles waiting for locked per attempt (>=1)
//   STABLE_CYC   1024       consecutive synced-locked cycles required before release (>=1)
//   MAX_RETRY    3          lock attempts allowed before FAIL (>=1)
//   LOST_W       8          width of the lock-loss event counter
// PORTS
//   clk        in   1                     board input clock; all logic on posedge
//   rst        in   1                     synchronous, active-low reset
//   locked     in   1                     clk_wiz locked; asynchronous, synced internally
//   restart    in   1                     one-cycle pulse forcing a new PLL reset sequence
//   pll_reset  out  1                     to clk_wiz reset input, active-high
//   sys_rst_n  out  1                     datapath reset, active-low, 1 only in RUN
//   state      out  3                     0 PLLRST, 1 WAIT, 2 STABLE, 3 RUN, 4 FAIL
//   retry_cnt  out  $clog2(MAX_RETRY+1)   failed attempts in the current sequence
//   lost_cnt   out  LOST_W                lock-loss events seen in RUN; saturating
//   fail       out  1                     high in FAIL
// BEHAVIOUR
//   - All outputs registered. While rst=0: state=PLLRST, pll_reset=1, sys_rst_n=0.
//     Also timer=0, retry_cnt=0, lost_cnt=0, fail=0, sync flops=0.
//   - locked passes through a 2-flop synchronizer (locked_s), adding 2 cycles of latency.
//   - Timer is cleared on every state entry and counts cycles spent in the state.
//   - PLLRST: pll_reset=1, sys_rst_n=0. When timer==RST_CYC-1, go to WAIT.
//   - WAIT: pll_reset=0. If locked_s=1, go to STABLE.
//     - Else if timer==LOCK_TIMEOUT-1: increment retry_cnt.
//     - If the new value equals MAX_RETRY, go to FAIL; otherwise go to PLLRST.
//   - STABLE: if locked_s=0, go back to WAIT. The WAIT timer restarts; retry_cnt is unchanged.
//     - If locked_s=1 and timer==STABLE_CYC-1, go to RUN.
//   - RUN: sys_rst_n=1 and retry_cnt is cleared on entry.
//     - If locked_s=0: sys_rst_n drops to 0 on that same edge, lost_cnt increments
//       (holds at all-ones), and the block goes to PLLRST.
//   - FAIL: pll_reset=0, sys_rst_n=0, fail=1. Only rst or restart leaves FAIL.
//   - restart=1 in any state, including mid-sequence: go to PLLRST, clear retry_cnt and fail.
//     lost_cnt is not cleared.
//   - Priority: rst > restart > lock loss / timeout > normal progression.
//   - sys_rst_n never glitches high outside RUN; it goes high at most once per sequence.
//   - Timer width is $clog2(max(RST_CYC, LOCK_TIMEOUT, STABLE_CYC)). It never wraps,
//     because every state exits at its terminal count.
// TESTING (bench params: RST_CYC=4, LOCK_TIMEOUT=20, STABLE_CYC=8, MAX_RETRY=2)
//   1 Nominal bring-up. rst released at edge 0, locked rises at edge 10.
//     -> pll_reset high for edges 0-3.
//     -> STABLE entered at edge 12, sys_rst_n=1 and state=3 from edge 20.
//   2 Lock never asserts.
//     -> WAIT times out at 20 cycles; retry_cnt goes 1, then 2.
//     -> FAIL after the second timeout; fail=1, pll_reset=0, sys_rst_n=0.
//   3 In STABLE, locked drops for 1 cycle after 5 cycles.
//     -> Back to WAIT, retry_cnt unchanged.
//     -> After relock, a full 8-cycle STABLE is required again before RUN.
//   4 In RUN, locked drops.
//     -> sys_rst_n=0 two cycles after the drop, lost_cnt +1, pll_reset high for 4 cycles.
//     -> Normal re-bring-up follows.
//     -> Force lost_cnt=255, then one more loss: lost_cnt stays at 255.
//   5 restart pulsed in FAIL, and again in STABLE.
//     -> PLLRST next edge, retry_cnt=0, fail=0.
//     -> Assert rst while in RUN: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/clk_lock_seq.sv
// Clock-wizard bring-up sequencer: pulses pll_reset, waits for a qualified lock,
// then releases the datapath reset; retries on timeout and re-sequences on lock loss.
module clk_lock_seq #(
  parameter int RST_CYC      = 16,
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int STABLE_CYC   = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int LOST_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 locked,
  input  logic                                 restart,
  output logic                                 pll_reset,
  output logic                                 sys_rst_n,
  output logic [2:0]                           state,
  output logic [$clog2(MAX_RETRY+1)-1:0]       retry_cnt,
  output logic [LOST_W-1:0]                    lost_cnt,
  output logic                                 fail
);

  localparam int RW     = $clog2(MAX_RETRY + 1);
  localparam int MAX_AB = (RST_CYC > LOCK_TIMEOUT) ? RST_CYC : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
  localparam int TW     = (MAX_T < 2) ? 1 : $clog2(MAX_T);

  localparam logic [TW-1:0]     RST_LAST    = TW'(RST_CYC - 1);
  localparam logic [TW-1:0]     WAIT_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]     STABLE_LAST = TW'(STABLE_CYC - 1);
  localparam logic [RW-1:0]     RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [LOST_W-1:0] LOST_MAX    = {LOST_W{1'b1}};

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [TW-1:0]     timer_r, timer_nxt_s;
  logic [RW-1:0]     retry_r, retry_nxt_s, retry_inc_s;
  logic [LOST_W-1:0] lost_r, lost_nxt_s;
  logic              locked_meta_r, locked_sync_r;

  // Next-state, timer, retry and lock-loss bookkeeping
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    lost_nxt_s  = lost_r;
    retry_inc_s = retry_r + RW'(1);
    if (restart) begin
      state_nxt_s = ST_PLLRST;
      retry_nxt_s = {RW{1'b0}};
    end else begin
      case (state_r)
        ST_PLLRST: begin
          if (timer_r == RST_LAST) state_nxt_s = ST_WAIT;
          else                     state_nxt_s = ST_PLLRST;
        end
        ST_WAIT: begin
          if (locked_sync_r) begin
            state_nxt_s = ST_STABLE;
          end else if (timer_r == WAIT_LAST) begin
            retry_nxt_s = retry_inc_s;
            // The attempt that reaches the limit parks in FAIL rather than retrying
            if (retry_inc_s == RETRY_LIMIT) state_nxt_s = ST_FAIL;
            else                            state_nxt_s = ST_PLLRST;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_STABLE: begin
          if (!locked_sync_r) begin
            state_nxt_s = ST_WAIT;
          end else if (timer_r == STABLE_LAST) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = {RW{1'b0}};
          end else begin
            state_nxt_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!locked_sync_r) begin
            state_nxt_s = ST_PLLRST;
            if (lost_r == LOST_MAX) lost_nxt_s = lost_r;
            else                    lost_nxt_s = lost_r + LOST_W'(1);
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAIL: state_nxt_s = ST_FAIL;
        default: state_nxt_s = ST_PLLRST;
      endcase
    end
    // RUN and FAIL have no terminal count, so the timer holds there instead of wrapping
    if (restart || (state_nxt_s != state_r))              timer_nxt_s = {TW{1'b0}};
    else if ((state_r == ST_RUN) || (state_r == ST_FAIL)) timer_nxt_s = timer_r;
    else                                                  timer_nxt_s = timer_r + TW'(1);
  end

  // State, counters, lock synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_PLLRST;
      timer_r       <= {TW{1'b0}};
      retry_r       <= {RW{1'b0}};
      lost_r        <= {LOST_W{1'b0}};
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
      pll_reset     <= 1'b1;
      sys_rst_n     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      retry_r       <= retry_nxt_s;
      lost_r        <= lost_nxt_s;
      locked_meta_r <= locked;
      locked_sync_r <= locked_meta_r;
      pll_reset     <= (state_nxt_s == ST_PLLRST);
      sys_rst_n     <= (state_nxt_s == ST_RUN);
      fail          <= (state_nxt_s == ST_FAIL);
    end
  end

  assign state     = state_r;
  assign retry_cnt = retry_r;
  assign lost_cnt  = lost_r;

endmodule

// File: tb/tb_clk_lock_seq.sv
// Directed bench for clk_lock_seq; edge numbers in comments count posedges from
// the last edge that samples rst low (edge 0) or from a named reference edge.
module tb_clk_lock_seq;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic       fail;

  int checks;
  int errors;

  clk_lock_seq #(
    .RST_CYC(4), .LOCK_TIMEOUT(20), .STABLE_CYC(8), .MAX_RETRY(2), .LOST_W(8)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .restart(restart),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .state(state),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while ((state !== target) && (n < budget)) begin
      step(1);
      n = n + 1;
    end
    check_eq(tag, 32'(state), 32'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_pll"},   32'(pll_reset), 32'd1);
    check_eq({tag, "_sys"},   32'(sys_rst_n), 32'd0);
    check_eq({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    check_eq({tag, "_lost"},  32'(lost_cnt), 32'd0);
    check_eq({tag, "_fail"},  32'(fail), 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    step(2);                                   // edge 0
    check_reset_vals("rst");
    rst = 1'b1;

    // 1: nominal bring-up, locked sampled high at edge 10
    step(3);                                   // edge 3
    check_eq("s1_pll_e3",   32'(pll_reset), 32'd1);
    check_eq("s1_state_e3", 32'(state), 32'd0);
    step(1);                                   // edge 4
    check_eq("s1_state_e4", 32'(state), 32'd1);
    check_eq("s1_pll_e4",   32'(pll_reset), 32'd0);
    step(5);                                   // edge 9
    locked = 1'b1;
    step(2);                                   // edge 11
    check_eq("s1_state_e11", 32'(state), 32'd1);
    step(1);                                   // edge 12
    check_eq("s1_state_e12", 32'(state), 32'd2);
    step(7);                                   // edge 19
    check_eq("s1_state_e19", 32'(state), 32'd2);
    check_eq("s1_sys_e19",   32'(sys_rst_n), 32'd0);
    step(1);                                   // edge 20
    check_eq("s1_state_e20", 32'(state), 32'd3);
    check_eq("s1_sys_e20",   32'(sys_rst_n), 32'd1);

    // 4: lock lost in RUN, sampled low at edge 23
    step(2);                                   // edge 22
    locked = 1'b0;
    step(2);                                   // edge 24
    check_eq("s4_state_e24", 32'(state), 32'd3);
    check_eq("s4_sys_e24",   32'(sys_rst_n), 32'd1);
    step(1);                                   // edge 25
    check_eq("s4_state_e25", 32'(state), 32'd0);
    check_eq("s4_sys_e25",   32'(sys_rst_n), 32'd0);
    check_eq("s4_pll_e25",   32'(pll_reset), 32'd1);
    check_eq("s4_lost_e25",  32'(lost_cnt), 32'd1);
    step(3);                                   // edge 28
    check_eq("s4_pll_e28",   32'(pll_reset), 32'd1);
    step(1);                                   // edge 29
    check_eq("s4_state_e29", 32'(state), 32'd1);
    check_eq("s4_pll_e29",   32'(pll_reset), 32'd0);
    locked = 1'b1;
    step(10);                                  // edge 39
    check_eq("s4_state_e39", 32'(state), 32'd2);
    step(1);                                   // edge 40
    check_eq("s4_state_e40", 32'(state), 32'd3);
    check_eq("s4_sys_e40",   32'(sys_rst_n), 32'd1);

    // 4b: drive lost_cnt to saturation, then one more loss
    for (int k = 0; k < 254; k++) begin
      locked = 1'b0;
      wait_state("s4_sat_drop", 3'd0, 10);
      locked = 1'b1;
      wait_state("s4_sat_run", 3'd3, 40);
    end
    check_eq("s4_lost_255", 32'(lost_cnt), 32'd255);
    locked = 1'b0;
    wait_state("s4_sat_drop_last", 3'd0, 10);
    check_eq("s4_lost_hold", 32'(lost_cnt), 32'd255);
    locked = 1'b1;
    wait_state("s4_sat_run_last", 3'd3, 40);

    // 3: one timeout, then a lock glitch in STABLE; restart sampled at edge R
    restart = 1'b1;
    locked  = 1'b0;
    step(1);                                   // R
    restart = 1'b0;
    check_eq("s3_state_r",  32'(state), 32'd0);
    check_eq("s3_retry_r",  32'(retry_cnt), 32'd0);
    check_eq("s3_lost_r",   32'(lost_cnt), 32'd255);
    step(4);                                   // R+4
    check_eq("s3_state_r4", 32'(state), 32'd1);
    step(19);                                  // R+23
    check_eq("s3_state_r23", 32'(state), 32'd1);
    check_eq("s3_retry_r23", 32'(retry_cnt), 32'd0);
    step(1);                                   // R+24
    check_eq("s3_state_r24", 32'(state), 32'd0);
    check_eq("s3_retry_r24", 32'(retry_cnt), 32'd1);
    step(2);                                   // R+26
    locked = 1'b1;
    step(2);                                   // R+28
    check_eq("s3_state_r28", 32'(state), 32'd1);
    step(1);                                   // S = R+29
    check_eq("s3_state_s",  32'(state), 32'd2);
    check_eq("s3_retry_s",  32'(retry_cnt), 32'd1);
    step(4);                                   // S+4
    locked = 1'b0;
    step(1);                                   // S+5
    locked = 1'b1;
    step(1);                                   // S+6
    check_eq("s3_state_s6", 32'(state), 32'd2);
    step(1);                                   // S+7
    check_eq("s3_state_s7", 32'(state), 32'd1);
    check_eq("s3_retry_s7", 32'(retry_cnt), 32'd1);
    step(1);                                   // S+8
    check_eq("s3_state_s8", 32'(state), 32'd2);
    step(7);                                   // S+15
    check_eq("s3_state_s15", 32'(state), 32'd2);
    check_eq("s3_sys_s15",   32'(sys_rst_n), 32'd0);
    step(1);                                   // S+16
    check_eq("s3_state_s16", 32'(state), 32'd3);
    check_eq("s3_retry_s16", 32'(retry_cnt), 32'd0);
    check_eq("s3_sys_s16",   32'(sys_rst_n), 32'd1);

    // 2: lock never asserts; restart sampled at edge R
    restart = 1'b1;
    locked  = 1'b0;
    step(1);                                   // R
    restart = 1'b0;
    check_eq("s2_state_r",  32'(state), 32'd0);
    step(4);                                   // R+4
    check_eq("s2_state_r4", 32'(state), 32'd1);
    step(20);                                  // R+24
    check_eq("s2_state_r24", 32'(state), 32'd0);
    check_eq("s2_retry_r24", 32'(retry_cnt), 32'd1);
    step(4);                                   // R+28
    check_eq("s2_state_r28", 32'(state), 32'd1);
    step(19);                                  // R+47
    check_eq("s2_state_r47", 32'(state), 32'd1);
    check_eq("s2_retry_r47", 32'(retry_cnt), 32'd1);
    step(1);                                   // R+48
    check_eq("s2_state_r48", 32'(state), 32'd4);
    check_eq("s2_fail_r48",  32'(fail), 32'd1);
    check_eq("s2_pll_r48",   32'(pll_reset), 32'd0);
    check_eq("s2_sys_r48",   32'(sys_rst_n), 32'd0);
    check_eq("s2_retry_r48", 32'(retry_cnt), 32'd2);
    step(7);
    check_eq("s2_state_hold", 32'(state), 32'd4);
    check_eq("s2_fail_hold",  32'(fail), 32'd1);

    // 5: restart from FAIL, restart from STABLE, then rst in RUN
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_eq("s5_state_fail", 32'(state), 32'd0);
    check_eq("s5_retry_fail", 32'(retry_cnt), 32'd0);
    check_eq("s5_fail_fail",  32'(fail), 32'd0);
    check_eq("s5_pll_fail",   32'(pll_reset), 32'd1);
    locked = 1'b1;
    wait_state("s5_to_stable", 3'd2, 20);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_eq("s5_state_stable", 32'(state), 32'd0);
    check_eq("s5_retry_stable", 32'(retry_cnt), 32'd0);
    wait_state("s5_to_run", 3'd3, 30);
    check_eq("s5_sys_run", 32'(sys_rst_n), 32'd1);
    rst = 1'b0;
    step(1);
    check_reset_vals("s5_rst");
    rst = 1'b1;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
